// File: rtl/alarm_pkg.sv
// Shared alarm types and derived timing helpers for the buzzer and controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_SNOOZE,
        ST_DONE
    } alarm_buz_state_t;

    localparam int MS_PER_SEC = 1000;

    function automatic int cyc_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    function automatic int tone_half(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/buzz_prescaler.sv
// Millisecond / second tick generator and buzzer tone phase.
// restart_i clears every counter; tone_restart_i clears only the tone phase.
module buzz_prescaler
    import alarm_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TONE_HZ = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic tone_restart_i,
    output logic ms_tick_o,
    output logic sec_tick_o,
    output logic phase_nxt_o
);

    localparam int CYC_MS = cyc_per_ms(CLK_HZ);
    localparam int HALF   = tone_half(CLK_HZ, TONE_HZ);
    localparam int MW     = $clog2(CYC_MS + 1);
    localparam int SW     = $clog2(MS_PER_SEC + 1);
    localparam int TW     = $clog2(HALF + 1);

    logic [MW-1:0] ms_q, ms_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [TW-1:0] tone_q, tone_d;
    logic          phase_q, phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_q    <= '0;
            sec_q   <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        ms_tick_o  = (ms_q == MW'(CYC_MS - 1));
        sec_tick_o = ms_tick_o && (sec_q == SW'(MS_PER_SEC - 1));
        ms_d       = ms_tick_o ? '0 : ms_q + 1'b1;
        sec_d      = sec_q;
        if (sec_tick_o) begin
            sec_d = '0;
        end else if (ms_tick_o) begin
            sec_d = sec_q + 1'b1;
        end
        tone_d  = tone_q + 1'b1;
        phase_d = phase_q;
        if (tone_q == TW'(HALF - 1)) begin
            tone_d  = '0;
            phase_d = ~phase_q;
        end
        if (restart_i) begin
            ms_d  = '0;
            sec_d = '0;
        end
        if (restart_i || tone_restart_i) begin
            tone_d  = '0;
            phase_d = 1'b0;
        end
        phase_nxt_o = phase_d;
    end

endmodule

// File: rtl/alarm_buzzer.sv
// Beep-pattern FSM with timeout auto-stop; snooze built only with ALARM_SNOOZE_EN.
// Outputs are registered from the next state so they line up with the state register.
module alarm_buzzer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TONE_HZ     = 2000,
    parameter int BEEP_ON_MS  = 250,
    parameter int BEEP_OFF_MS = 250,
    parameter int TIMEOUT_S   = 60,
    parameter int SNOOZE_S    = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic alarm_ringing,
    input  logic snooze_p,
    output logic buzzer_out,
    output logic beep_active,
    output logic snoozing,
    output logic auto_stop_p
);

    localparam int BMAX = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int TOW  = $clog2(TIMEOUT_S + 1);

    alarm_buz_state_t state_q, state_d;
    logic [BW-1:0]    beep_q, beep_d;
    logic [TOW-1:0]   to_q, to_d;
    logic             buzz_q, buzz_d;
    logic             act_q, act_d;
    logic             stop_q, stop_d;

    logic ms_tick, sec_tick, phase_nxt;
    logic restart, tone_restart;
    logic in_pat_q, in_pat_d;
    logic timeout, beep_done, snz_req, snz_done;

    buzz_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TONE_HZ(TONE_HZ)
    ) u_pre (
        .clk           (clk),
        .rst           (rst),
        .restart_i     (restart),
        .tone_restart_i(tone_restart),
        .ms_tick_o     (ms_tick),
        .sec_tick_o    (sec_tick),
        .phase_nxt_o   (phase_nxt)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int SNW = $clog2(SNOOZE_S + 1);
    logic [SNW-1:0] sn_q, sn_d;
    logic           snz_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sn_q      <= '0;
            snz_out_q <= 1'b0;
        end else begin
            sn_q      <= sn_d;
            snz_out_q <= (state_d == ST_SNOOZE);
        end
    end

    always_comb begin
        sn_d = '0;
        if (state_q == ST_SNOOZE && state_d == ST_SNOOZE) begin
            sn_d = sec_tick ? sn_q + 1'b1 : sn_q;
        end
    end

    assign snz_req  = snooze_p;
    assign snz_done = sec_tick && (sn_q == SNW'(SNOOZE_S - 1));
    assign snoozing = snz_out_q;
`else
    logic unused_cfg;
    assign unused_cfg = snooze_p ^ (SNOOZE_S > 0);
    assign snz_req    = 1'b0;
    assign snz_done   = 1'b0;
    assign snoozing   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beep_q  <= '0;
            to_q    <= '0;
            buzz_q  <= 1'b0;
            act_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beep_q  <= beep_d;
            to_q    <= to_d;
            buzz_q  <= buzz_d;
            act_q   <= act_d;
            stop_q  <= stop_d;
        end
    end

    assign in_pat_q  = (state_q == ST_ON) || (state_q == ST_OFF);
    assign timeout   = sec_tick && (to_q == TOW'(TIMEOUT_S - 1));
    assign beep_done = ms_tick && (beep_q == ((state_q == ST_ON) ?
                       BW'(BEEP_ON_MS - 1) : BW'(BEEP_OFF_MS - 1)));

    // Priority: alarm drop, then timeout, then snooze, then beep toggle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_ON;
            ST_ON, ST_OFF: begin
                if (timeout) begin
                    state_d = ST_DONE;
                end else if (snz_req) begin
                    state_d = ST_SNOOZE;
                end else if (beep_done) begin
                    state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
                end
            end
            ST_SNOOZE: state_d = snz_done ? ST_ON : ST_SNOOZE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
        if (!alarm_ringing) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        in_pat_d     = (state_d == ST_ON) || (state_d == ST_OFF);
        restart      = ((state_q == ST_IDLE) && (state_d == ST_ON)) ||
                       ((state_q != ST_SNOOZE) && (state_d == ST_SNOOZE));
        tone_restart = (state_q != ST_ON) && (state_d == ST_ON);
        beep_d       = beep_q;
        if (state_d != state_q) begin
            beep_d = '0;
        end else if (ms_tick && in_pat_q) begin
            beep_d = beep_q + 1'b1;
        end
        to_d = '0;
        if (in_pat_q && in_pat_d) begin
            to_d = sec_tick ? to_q + 1'b1 : to_q;
        end
    end

    always_comb begin
        buzz_d = (state_d == ST_ON) && phase_nxt;
        act_d  = in_pat_d;
        stop_d = in_pat_q && (state_d == ST_DONE);
    end

    assign buzzer_out  = buzz_q;
    assign beep_active = act_q;
    assign auto_stop_p = stop_q;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Directed scoreboard bench for alarm_buzzer; honours ALARM_SNOOZE_EN.
module tb_alarm_buzzer;

    localparam int CLK_HZ  = 8000;
    localparam int TONE_HZ = 1000;
    localparam int ON_MS   = 2;
    localparam int OFF_MS  = 2;
    localparam int TO_S    = 2;
    localparam int SNZ_S   = 1;

    localparam int CYC_MS = CLK_HZ / 1000;
    localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
    localparam int ON_C   = ON_MS * CYC_MS;
    localparam int PER    = (ON_MS + OFF_MS) * CYC_MS;
    localparam int SEC    = CLK_HZ;
    localparam int TO_C   = TO_S * SEC;
    localparam int SNZ_C  = SNZ_S * SEC;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic alarm_ringing;
    logic snooze_p;
    logic buzzer_out;
    logic beep_active;
    logic snoozing;
    logic auto_stop_p;

    logic [3:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alarm_buzzer #(
        .CLK_HZ     (CLK_HZ),
        .TONE_HZ    (TONE_HZ),
        .BEEP_ON_MS (ON_MS),
        .BEEP_OFF_MS(OFF_MS),
        .TIMEOUT_S  (TO_S),
        .SNOOZE_S   (SNZ_S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alarm_ringing(alarm_ringing),
        .snooze_p     (snooze_p),
        .buzzer_out   (buzzer_out),
        .beep_active  (beep_active),
        .snoozing     (snoozing),
        .auto_stop_p  (auto_stop_p)
    );

    // {buzzer_out, beep_active, snoozing, auto_stop_p}, t cycles after ON entry
    function automatic logic [3:0] pat(input int t);
        int  p;
        logic b;
        p = t % PER;
        b = (p < ON_C) && (((p / HALF) % 2) == 1);
        return {b, 1'b1, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] e;
        obs = {buzzer_out, beep_active, snoozing, auto_stop_p};
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s: got %b want %b at %0t", tag, obs, e, $time);
        end
    endtask

    initial begin
        rst           = 1'b1;
        alarm_ringing = 1'b0;
        snooze_p      = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(4'b0000);
        check("reset");
        rst = 1'b0;
        step();
        exp_q.push_back(4'b0000);
        check("idle");

        alarm_ringing = 1'b1;
        for (int t = 0; t < 69; t++) begin
            step();
            exp_q.push_back(pat(t));
            check("pattern");
        end

        rst = 1'b1;
        #1;
        exp_q.push_back(4'b0000);
        check("rst_async");
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(4'b0000);
        check("rst_idle");
        for (int t = 0; t < 40; t++) begin
            step();
            exp_q.push_back(pat(t));
            check("restart");
        end

        alarm_ringing = 1'b0;
        step();
        exp_q.push_back(4'b0000);
        check("drop");
        alarm_ringing = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            exp_q.push_back(pat(t));
            check("reraise");
        end

        alarm_ringing = 1'b0;
        step();
        exp_q.push_back(4'b0000);
        check("idle2");
        alarm_ringing = 1'b1;
        for (int t = 0; t <= TO_C + 100; t++) begin
            snooze_p = (t == TO_C) || (!SNZ && t == 100);
            step();
            snooze_p = 1'b0;
            if (t < TO_C) exp_q.push_back(pat(t));
            else if (t == TO_C) exp_q.push_back(4'b0001);
            else exp_q.push_back(4'b0000);
            check("timeout");
        end
        alarm_ringing = 1'b0;
        step();
        exp_q.push_back(4'b0000);
        check("done_exit");

`ifdef ALARM_SNOOZE_EN
        alarm_ringing = 1'b1;
        for (int t = 0; t <= SEC + 20; t++) begin
            step();
            exp_q.push_back(pat(t));
            check("pre_snz");
        end
        snooze_p = 1'b1;
        step();
        snooze_p = 1'b0;
        exp_q.push_back(4'b0010);
        check("snz_enter");
        for (int k = 1; k <= SNZ_C; k++) begin
            snooze_p = (k == SNZ_C / 2);
            step();
            snooze_p = 1'b0;
            exp_q.push_back((k < SNZ_C) ? 4'b0010 : pat(0));
            check("snoozing");
        end
        for (int t = 1; t <= TO_C; t++) begin
            step();
            exp_q.push_back((t < TO_C) ? pat(t) : 4'b0001);
            check("post_snz");
        end
        alarm_ringing = 1'b0;
        step();
        exp_q.push_back(4'b0000);
        check("snz_exit");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
